if_fetch_unit: RTL and testbench
================================

# if_fetch_unit

Instruction-fetch stage of the 5-stage MIPS pipeline: holds the program counter, issues one word read at a time to instruction memory, and presents the fetched instruction plus PC+4 to the IF/ID pipeline register. It absorbs variable memory latency, holds a fetched instruction while decode is stalled, and discards in-flight fetches on branch/jump redirects. `valid_o` low tells the hazard unit to load a bubble (Clr) into IF/ID.

## Interface
- `RESET_PC`, 32'h0000_0000, PC value after reset; bits [1:0] must be 0.
- `clk`  in  1  clock; all state updates on posedge.
- `rst`  in  1  asynchronous, active-low reset.
- `stall_i`  in  1  decode stall from hazard unit; the presented instruction is not consumed this cycle.
- `redirect_i`  in  1  taken branch/jump; overrides stall.
- `redirect_addr_i`  in  32  redirect target; bits [1:0] ignored (treated as 0).
- `imem_req_o`  out  1  one-cycle read request.
- `imem_addr_o`  out  32  word address of request, `{pc[31:2],2'b00}`.
- `imem_rvalid_i`  in  1  read data valid; arrives ≥1 cycle after `imem_req_o`.
- `imem_rdata_i`  in  32  instruction word.
- `instr_o`  out  32  instruction to IF/ID (`Instr_i`).
- `pc_plus4_o`  out  32  fetch address + 4 to IF/ID (`RefAddr_i`).
- `valid_o`  out  1  `instr_o`/`pc_plus4_o` hold a real instruction.

## Operation
- State: `pc` (32b), FSM {ISSUE, WAIT, HELD, KILL}, hold register `hold_instr` (32b).
- One memory request outstanding at most. Memory returns exactly one `imem_rvalid_i` per request, in order.
- ISSUE: `imem_req_o`=1. Redirect → pc←target, KILL. Else → WAIT.
- WAIT: `imem_req_o`=0. Redirect → pc←target; ISSUE if `imem_rvalid_i` else KILL (response discarded, never presented). Else if rvalid & !stall: present, pc←pc+4, ISSUE. Rvalid & stall: present, hold_instr←rdata, HELD. No rvalid: stay.
- HELD: present hold_instr. Redirect → pc←target, ISSUE (held instr dropped). !stall → pc←pc+4, ISSUE. Else stay.
- KILL: waits for the stale response. Rvalid → discard, ISSUE. Redirect in KILL → pc←target, stay KILL.
- Presentation (combinational): WAIT with rvalid & !redirect → instr_o=rdata, valid_o=1. HELD & !redirect → instr_o=hold_instr, valid_o=1. Otherwise instr_o=0 (NOP), valid_o=0. pc_plus4_o = pc+4 when valid_o, else 0.
- pc+4 wraps modulo 2^32 (0xFFFF_FFFC → 0x0000_0000).
- Redirect has priority over stall and over an arriving response in every state.

## Timing
- Reset (async assert): pc=RESET_PC, state=ISSUE, hold_instr=0; valid_o=0, instr_o=0, pc_plus4_o=0, imem_req_o=0 while rst low. First request in first cycle after rst deasserts.
- Best-case throughput: 1 instruction per 2 cycles (ISSUE, WAIT+rvalid).
- Fetch latency: request cycle → instruction presented in the cycle rvalid arrives (same-cycle pass-through, no extra register).
- Redirect to first request of target: 1 cycle if no fetch outstanding, else 1 cycle after stale rvalid.
- Reset mid-operation: all state cleared immediately; an outstanding memory response arriving after reset release while in ISSUE is a memory-side protocol violation (memory shares `rst`).

## Test plan
- Reset release, RESET_PC=0, memory latency 1, words 0x2008_0001, 0x2009_0002 → imem_addr 0x0, 0x4; valid_o pulses with pc_plus4_o 0x4 then 0x8, one instr per 2 cycles.
- Latency 3 with stall_i high 2 cycles at delivery of 0x0109_5020 @0x10 → HELD, instr_o=0x0109_5020, pc_plus4_o=0x14 steady 3 cycles, next imem_addr 0x14.
- Redirect to 0x0000_0103 in WAIT before rvalid → KILL; stale data never on valid_o; next imem_addr 0x100.
- Redirect coincident with rvalid and stall → response dropped, valid_o=0 that cycle, next cycle imem_addr=target.
- Redirect while HELD → held instr dropped, next cycle ISSUE at target; redirect twice in KILL → last target fetched.
- PC wrap: redirect to 0xFFFF_FFFC, deliver → pc_plus4_o=0x0000_0000, next imem_addr 0x0; async rst mid-WAIT → outputs 0 immediately, refetch from RESET_PC.

Source files
------------

// File: rtl/if_fetch_unit_if.sv
// Fetch-stage bundle: decode-side control, instruction-memory port and IF/ID outputs.
interface if_fetch_unit_if;
  logic        stall_i;
  logic        redirect_i;
  logic [31:0] redirect_addr_i;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_rvalid_i;
  logic [31:0] imem_rdata_i;
  logic [31:0] instr_o;
  logic [31:0] pc_plus4_o;
  logic        valid_o;

  // Fetch unit side
  modport master (
    input  stall_i, redirect_i, redirect_addr_i, imem_rvalid_i, imem_rdata_i,
    output imem_req_o, imem_addr_o, instr_o, pc_plus4_o, valid_o
  );

  // Pipeline / memory environment side
  modport slave (
    output stall_i, redirect_i, redirect_addr_i, imem_rvalid_i, imem_rdata_i,
    input  imem_req_o, imem_addr_o, instr_o, pc_plus4_o, valid_o
  );
endinterface

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: PC, single-outstanding imem read, stall hold and redirect kill.
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic           clk,
  input  logic           rst,
  if_fetch_unit_if.master bus
);

  typedef enum logic [1:0] {
    ST_ISSUE,
    ST_WAIT,
    ST_HELD,
    ST_KILL
  } state_e;

  state_e      state_q;
  logic [31:0] pc_q;
  logic [31:0] hold_instr_q;

  logic [31:0] target;
  logic [31:0] pc_plus4;
  logic        present;
  logic [31:0] instr;

  assign target   = bus.redirect_addr_i & 32'hFFFF_FFFC;
  assign pc_plus4 = pc_q + 32'd4;

  // Presentation to IF/ID: same-cycle pass-through of memory data, or the held word
  always_comb begin
    present = 1'b0;
    instr   = '0;
    if (!bus.redirect_i) begin
      if (state_q == ST_WAIT && bus.imem_rvalid_i) begin
        present = 1'b1;
        instr   = bus.imem_rdata_i;
      end else if (state_q == ST_HELD) begin
        present = 1'b1;
        instr   = hold_instr_q;
      end
    end
  end

  // Request is gated by rst so nothing is issued while reset is held
  assign bus.imem_req_o  = rst && (state_q == ST_ISSUE);
  assign bus.imem_addr_o = pc_q & 32'hFFFF_FFFC;
  assign bus.valid_o     = present;
  assign bus.instr_o     = instr;
  assign bus.pc_plus4_o  = present ? pc_plus4 : '0;

  // Fetch FSM: redirect wins over stall and over an arriving response
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_ISSUE;
      pc_q         <= RESET_PC;
      hold_instr_q <= '0;
    end else begin
      case (state_q)
        ST_ISSUE: begin
          if (bus.redirect_i) begin
            pc_q    <= target;
            state_q <= ST_KILL;
          end else begin
            state_q <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (bus.redirect_i) begin
            pc_q    <= target;
            state_q <= bus.imem_rvalid_i ? ST_ISSUE : ST_KILL;
          end else if (bus.imem_rvalid_i) begin
            if (bus.stall_i) begin
              hold_instr_q <= bus.imem_rdata_i;
              state_q      <= ST_HELD;
            end else begin
              pc_q    <= pc_plus4;
              state_q <= ST_ISSUE;
            end
          end
        end
        ST_HELD: begin
          if (bus.redirect_i) begin
            pc_q    <= target;
            state_q <= ST_ISSUE;
          end else if (!bus.stall_i) begin
            pc_q    <= pc_plus4;
            state_q <= ST_ISSUE;
          end
        end
        ST_KILL: begin
          // A stale response that lands with a redirect still retires the
          // outstanding read, so go fetch the new target rather than wait again.
          if (bus.redirect_i) begin
            pc_q <= target;
          end
          if (bus.imem_rvalid_i) begin
            state_q <= ST_ISSUE;
          end
        end
        default: state_q <= ST_ISSUE;
      endcase
    end
  end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Self-checking bench for if_fetch_unit: behavioural fetch model plus randomized memory/pipeline.
module tb_if_fetch_unit;

  logic clk;
  logic rst;

  if_fetch_unit_if bus ();

  if_fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks;
  int n_err;

  // Behavioural model: architectural fetch pointer plus outstanding/held bookkeeping
  logic [31:0] exp_pc;
  bit          pending;
  bit          stale;
  bit          held;

  // Memory model
  bit          mem_busy;
  int          mem_cnt;
  logic [31:0] mem_addr;
  int          lat_cfg;

  // Last observed DUT outputs
  logic        obs_req;
  logic [31:0] obs_addr;
  logic        obs_valid;
  logic [31:0] obs_instr;
  logic [31:0] obs_p4;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h0000_0000: return 32'h2008_0001;
      32'h0000_0004: return 32'h2009_0002;
      32'h0000_0010: return 32'h0109_5020;
      default:       return {a[15:0] ^ 16'h5A5A, a[31:16]} ^ 32'h1357_9BDF;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    exp_pc   = 32'h0000_0000;
    pending  = 0;
    stale    = 0;
    held     = 0;
    mem_busy = 0;
    mem_cnt  = 0;
  endtask

  // One clock cycle: called at posedge+1, returns at next posedge+1
  task automatic step(input logic st, input logic rd, input logic [31:0] ra);
    logic        rv;
    logic [31:0] rdat;
    logic        e_req, e_valid;
    logic [31:0] e_instr, e_p4;
    int          lat;
    rv   = 1'b0;
    rdat = '0;
    if (mem_busy) begin
      mem_cnt--;
      if (mem_cnt == 0) begin
        rv   = 1'b1;
        rdat = mem_word(mem_addr);
      end
    end
    bus.stall_i         = st;
    bus.redirect_i      = rd;
    bus.redirect_addr_i = ra;
    bus.imem_rvalid_i   = rv;
    bus.imem_rdata_i    = rdat;
    @(negedge clk);

    e_req   = !pending && !held;
    e_valid = ((rv && !stale) || held) && !rd;
    e_instr = e_valid ? mem_word(exp_pc) : 32'h0;
    e_p4    = e_valid ? exp_pc + 32'd4 : 32'h0;

    obs_req   = bus.imem_req_o;
    obs_addr  = bus.imem_addr_o;
    obs_valid = bus.valid_o;
    obs_instr = bus.instr_o;
    obs_p4    = bus.pc_plus4_o;
    chk("imem_req", {31'b0, obs_req}, {31'b0, e_req});
    chk("imem_addr", obs_addr, exp_pc);
    chk("valid", {31'b0, obs_valid}, {31'b0, e_valid});
    chk("instr", obs_instr, e_instr);
    chk("pc_plus4", obs_p4, e_p4);

    // Memory reacts to what the DUT actually did
    if (rv) mem_busy = 0;
    if (obs_req) begin
      if (mem_busy) begin
        n_checks++;
        n_err++;
        $display("FAIL second_outstanding: got req with busy memory expected no req");
      end
      lat      = (lat_cfg == 0) ? int'($urandom_range(3, 1)) : lat_cfg;
      mem_busy = 1;
      mem_cnt  = lat;
      mem_addr = obs_addr;
    end

    // Advance model
    if (rd) begin
      if (e_req) begin
        pending = 1;
        stale   = 1;
      end else if (rv) begin
        pending = 0;
        stale   = 0;
      end else if (pending) begin
        stale = 1;
      end
      held   = 0;
      exp_pc = ra & 32'hFFFF_FFFC;
    end else begin
      if (e_req) begin
        pending = 1;
        stale   = 0;
      end
      if (rv) begin
        pending = 0;
        if (!stale) begin
          if (st) held = 1;
          else    exp_pc = exp_pc + 32'd4;
        end
        stale = 0;
      end else if (held && !st) begin
        held   = 0;
        exp_pc = exp_pc + 32'd4;
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_checks = 0;
    n_err    = 0;
    lat_cfg  = 1;
    model_reset();
    rst                 = 1'b0;
    bus.stall_i         = 1'b0;
    bus.redirect_i      = 1'b0;
    bus.redirect_addr_i = '0;
    bus.imem_rvalid_i   = 1'b0;
    bus.imem_rdata_i    = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req", {31'b0, bus.imem_req_o}, 32'h0);
    chk("rst_valid", {31'b0, bus.valid_o}, 32'h0);
    chk("rst_instr", bus.instr_o, 32'h0);
    chk("rst_p4", bus.pc_plus4_o, 32'h0);
    rst = 1'b1;

    // Back-to-back fetch, latency 1
    step(0, 0, 0);
    chk("t1_req0", {31'b0, obs_req}, 32'h1);
    chk("t1_addr0", obs_addr, 32'h0);
    step(0, 0, 0);
    chk("t1_instr0", obs_instr, 32'h2008_0001);
    chk("t1_p4_0", obs_p4, 32'h4);
    step(0, 0, 0);
    chk("t1_addr1", obs_addr, 32'h4);
    step(0, 0, 0);
    chk("t1_instr1", obs_instr, 32'h2009_0002);
    chk("t1_p4_1", obs_p4, 32'h8);

    // Move to 0x10, latency 3, stall two cycles at delivery
    step(0, 1, 32'h10);
    lat_cfg = 3;
    step(0, 0, 0);
    chk("t2_stale", {31'b0, obs_valid}, 32'h0);
    step(0, 0, 0);
    chk("t2_addr", obs_addr, 32'h10);
    step(0, 0, 0);
    step(0, 0, 0);
    step(1, 0, 0);
    chk("t2_d_instr", obs_instr, 32'h0109_5020);
    chk("t2_d_p4", obs_p4, 32'h14);
    step(1, 0, 0);
    chk("t2_h_instr", obs_instr, 32'h0109_5020);
    chk("t2_h_p4", obs_p4, 32'h14);
    step(0, 0, 0);
    chk("t2_r_valid", {31'b0, obs_valid}, 32'h1);
    chk("t2_r_p4", obs_p4, 32'h14);
    step(0, 0, 0);
    chk("t2_next_addr", obs_addr, 32'h14);

    // Redirect in WAIT before data: kill
    step(0, 1, 32'h0000_0103);
    chk("t3_valid", {31'b0, obs_valid}, 32'h0);
    step(0, 0, 0);
    chk("t3_kill_addr", obs_addr, 32'h100);
    step(0, 0, 0);
    chk("t3_stale", {31'b0, obs_valid}, 32'h0);
    lat_cfg = 1;
    step(0, 0, 0);
    chk("t3_issue", obs_addr, 32'h100);

    // Redirect coincident with rvalid and stall
    step(1, 1, 32'h200);
    chk("t4_valid", {31'b0, obs_valid}, 32'h0);
    step(0, 0, 0);
    chk("t4_req", {31'b0, obs_req}, 32'h1);
    chk("t4_addr", obs_addr, 32'h200);

    // Redirect while held, then redirect twice in KILL
    step(1, 0, 0);
    chk("t5_held", {31'b0, obs_valid}, 32'h1);
    step(1, 1, 32'h300);
    chk("t5_drop", {31'b0, obs_valid}, 32'h0);
    lat_cfg = 3;
    step(0, 0, 0);
    chk("t5_addr", obs_addr, 32'h300);
    step(0, 1, 32'h400);
    step(0, 1, 32'h500);
    step(0, 0, 0);
    chk("t5_stale", {31'b0, obs_valid}, 32'h0);
    step(0, 0, 0);
    chk("t5_last", obs_addr, 32'h500);

    // PC wrap
    step(0, 1, 32'hFFFF_FFFC);
    lat_cfg = 1;
    step(0, 0, 0);
    step(0, 0, 0);
    step(0, 0, 0);
    chk("t6_addr", obs_addr, 32'hFFFF_FFFC);
    step(0, 0, 0);
    chk("t6_valid", {31'b0, obs_valid}, 32'h1);
    chk("t6_p4", obs_p4, 32'h0);
    step(0, 0, 0);
    chk("t6_wrap_addr", obs_addr, 32'h0);

    // Async reset while waiting on a fetch
    lat_cfg = 3;
    step(0, 1, 32'h40);
    step(0, 0, 0);
    step(0, 0, 0);
    step(0, 0, 0);
    step(0, 0, 0);
    chk("t7_pre_addr", obs_addr, 32'h40);
    step(0, 0, 0);
    #2;
    rst = 1'b0;
    #1;
    chk("t7_req", {31'b0, bus.imem_req_o}, 32'h0);
    chk("t7_valid", {31'b0, bus.valid_o}, 32'h0);
    chk("t7_instr", bus.instr_o, 32'h0);
    chk("t7_p4", bus.pc_plus4_o, 32'h0);
    chk("t7_addr", bus.imem_addr_o, 32'h0);
    model_reset();
    bus.stall_i       = 1'b0;
    bus.redirect_i    = 1'b0;
    bus.imem_rvalid_i = 1'b0;
    bus.imem_rdata_i  = '0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    step(0, 0, 0);
    chk("t7_refetch", obs_addr, 32'h0);
    chk("t7_refetch_req", {31'b0, obs_req}, 32'h1);

    // Randomized traffic
    lat_cfg = 0;
    for (int i = 0; i < 800; i++) begin
      logic        st, rd;
      logic [31:0] ra;
      st = ($urandom_range(99, 0) < 30);
      rd = ($urandom_range(99, 0) < 10);
      if ($urandom_range(3, 0) == 0) ra = 32'hFFFF_FFF0 | ($urandom() & 32'hF);
      else                           ra = $urandom();
      step(st, rd, ra);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
